seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the BCD-to-7-segment path: snoops a multiplexed
//  7-segment display bus (shared segment lines + one-hot digit enables) and

---
 rtl/seg_scan_decoder_if.sv | 30 +++
 rtl/seg_scan_decoder.sv | 187 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_decoder_if.sv
// Bus bundle for seg_scan_decoder: the snooped display lines plus the rebuilt frame.
// The master side drives the display lines and consumes the decoded frame.
interface seg_scan_decoder_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [6:0]              seg_in;       // {a,b,c,d,e,f,g}
    logic [NUM_DIGITS-1:0]   dig_en;       // one-hot digit select
    logic [4*NUM_DIGITS-1:0] bcd_out;      // digit i in [4i+3:4i]
    logic [NUM_DIGITS-1:0]   digit_err;    // digit i held an illegal pattern
    logic                    frame_valid;  // bcd_out/digit_err just updated
    logic                    link_lost;    // no capture for the timeout window

    modport master (
        output seg_in,
        output dig_en,
        input  bcd_out,
        input  digit_err,
        input  frame_valid,
        input  link_lost
    );

    modport slave (
        input  seg_in,
        input  dig_en,
        output bcd_out,
        output digit_err,
        output frame_valid,
        output link_lost
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: snoops a multiplexed 7-segment bus (shared segments, one-hot digit
// enables) and rebuilds the BCD code of every digit. A frame is published once every
// digit has been captured since the previous frame; link_lost flags a silent bus.
// Build option: define SEG_ACTIVE_LOW_EN for common-anode displays (segments and
// enables active low); they are inverted before the input register.
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic                 clk,
    input logic                 rst,
    seg_scan_decoder_if.slave   bus
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(SETTLE_CYC);
    localparam logic [SW-1:0] STABLE_CAP = SW'(SETTLE_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        st_scan    = 2'd0,
        st_publish = 2'd1,
        st_lost    = 2'd2
    } state_e;

    // Segment pattern {a..g} to BCD; blank reads as F, anything unknown as E.
    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        logic [3:0] code;
        case (s)
            7'b1111110: code = 4'h0;
            7'b0110000: code = 4'h1;
            7'b1101101: code = 4'h2;
            7'b1111001: code = 4'h3;
            7'b0110011: code = 4'h4;
            7'b1011011: code = 4'h5;
            7'b0011111: code = 4'h6;
            7'b1110000: code = 4'h7;
            7'b1111111: code = 4'h8;
            7'b1110011: code = 4'h9;
            7'b0000000: code = 4'hF;
            default:    code = 4'hE;
        endcase
        return code;
    endfunction

    logic [6:0]              seg_pin;
    logic [NUM_DIGITS-1:0]   en_pin;

`ifdef SEG_ACTIVE_LOW_EN
    assign seg_pin = ~bus.seg_in;
    assign en_pin  = ~bus.dig_en;
`else
    assign seg_pin = bus.seg_in;
    assign en_pin  = bus.dig_en;
`endif

    logic [6:0]              r_seg, p_seg;
    logic [NUM_DIGITS-1:0]   r_en, p_en;
    logic [SW-1:0]           stable_cnt, stable_cnt_d;
    logic [IW-1:0]           idle_cnt, idle_cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow, shadow_d;
    logic [NUM_DIGITS-1:0]   mask, mask_d;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    link_lost_q;
    state_e                  state, state_d;

    logic                    cap;
    logic [NUM_DIGITS-1:0]   cap_bit;
    logic [3:0]              code;
    logic                    publish_now;
    logic                    lost_now;

    // Input register stage plus a one-cycle-delayed copy for the stability check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= '0;
            r_en  <= '0;
            p_seg <= '0;
            p_en  <= '0;
        end else begin
            r_seg <= seg_pin;
            r_en  <= en_pin;
            p_seg <= r_seg;
            p_en  <= r_en;
        end
    end

    // Settle counter, capture strobe, shadow update and idle counter.
    always_comb begin
        stable_cnt_d = '0;
        if ((r_seg == p_seg) && (r_en == p_en)) begin
            stable_cnt_d = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end

        // Fires once per dwell since the counter saturates past the capture point.
        cap     = (stable_cnt == STABLE_CAP) && $onehot(r_en);
        cap_bit = cap ? r_en : '0;
        code    = seg_decode(r_seg);

        shadow_d = shadow;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cap_bit[i]) begin
                shadow_d[4*i +: 4] = code;
            end
        end

        err_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            err_d[i] = (shadow_d[4*i +: 4] == 4'hE);
        end

        idle_cnt_d = '0;
        if (!cap) begin
            idle_cnt_d = (idle_cnt == IDLE_LAST) ? idle_cnt : idle_cnt + 1'b1;
        end
    end

    // Frame FSM: the frame is latched on the edge entering publish so frame_valid and
    // the new bcd_out appear together; a capture during publish starts the next mask.
    always_comb begin
        state_d     = state;
        mask_d      = mask | cap_bit;
        publish_now = 1'b0;
        lost_now    = 1'b0;
        case (state)
            st_scan: begin
                if (&(mask | cap_bit)) begin
                    state_d     = st_publish;
                    mask_d      = '0;
                    publish_now = 1'b1;
                end else if (!cap && (idle_cnt == IDLE_LAST)) begin
                    state_d  = st_lost;
                    mask_d   = '0;
                    lost_now = 1'b1;
                end
            end
            st_publish: begin
                state_d = st_scan;
            end
            st_lost: begin
                if (cap) begin
                    state_d = st_scan;
                end
            end
            default: begin
                state_d = st_scan;
                mask_d  = '0;
            end
        endcase
    end

    // State, capture bookkeeping and published frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= st_scan;
            stable_cnt  <= '0;
            idle_cnt    <= '0;
            shadow      <= {NUM_DIGITS{4'hF}};
            mask        <= '0;
            bcd_q       <= {NUM_DIGITS{4'hF}};
            err_q       <= '0;
            link_lost_q <= 1'b0;
        end else begin
            state      <= state_d;
            stable_cnt <= stable_cnt_d;
            idle_cnt   <= idle_cnt_d;
            shadow     <= shadow_d;
            mask       <= mask_d;
            if (publish_now) begin
                bcd_q       <= shadow_d;
                err_q       <= err_d;
                link_lost_q <= 1'b0;
            end else if (lost_now) begin
                link_lost_q <= 1'b1;
            end
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = (state == st_publish);
    assign bus.link_lost   = link_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans a 4-digit display through the bus
// interface and checks published frames, errors, short dwells, gaps, timeout and reset.
module tb_seg_scan_decoder;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 4;
    localparam int unsigned TO = 1024;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b0011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1110011;
    localparam logic [6:0] PBLANK = 7'b0000000;
    localparam logic [6:0] PBAD   = 7'b1000001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_decoder #(
        .NUM_DIGITS (ND),
        .SETTLE_CYC (SC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int fv_cnt = 0;
    int base;
    bit seen;

    // Count frame_valid pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dwell(input logic [6:0] s, input logic [3:0] en, input int n);
        bus.seg_in = s;
        bus.dig_en = en;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a pattern and stop at the first cycle frame_valid is seen (bounded).
    task automatic show_until_frame(input logic [6:0] s, input logic [3:0] en,
                                    output bit got);
        bus.seg_in = s;
        bus.dig_en = en;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.frame_valid === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.seg_in = '0;
        bus.dig_en = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd", 32'(bus.bcd_out), 32'hFFFF);
        chk("rst_err", 32'(bus.digit_err), 32'h0);
        chk("rst_fv", 32'(bus.frame_valid), 32'h0);
        chk("rst_ll", 32'(bus.link_lost), 32'h0);
        rst = 1'b0;
        dwell(PBLANK, 4'b0000, 3);

        // 1: plain scan 1,2,3,4
        base = fv_cnt;
        dwell(P1, 4'b0001, 8);
        dwell(P2, 4'b0010, 8);
        dwell(P3, 4'b0100, 8);
        chk("t1_nofv_early", 32'(fv_cnt - base), 32'd0);
        show_until_frame(P4, 4'b1000, seen);
        chk("t1_seen", 32'(seen), 32'd1);
        chk("t1_bcd", 32'(bus.bcd_out), 32'h4321);
        chk("t1_err", 32'(bus.digit_err), 32'h0);
        dwell(P4, 4'b1000, 4);
        dwell(PBLANK, 4'b0000, 4);
        chk("t1_fvcnt", 32'(fv_cnt - base), 32'd1);

        // 2: illegal pattern on digit 2
        base = fv_cnt;
        dwell(P1, 4'b0001, 8);
        dwell(P2, 4'b0010, 8);
        dwell(PBAD, 4'b0100, 8);
        show_until_frame(P4, 4'b1000, seen);
        chk("t2_seen", 32'(seen), 32'd1);
        chk("t2_bcd", 32'(bus.bcd_out), 32'h4E21);
        chk("t2_err", 32'(bus.digit_err), 32'h4);
        dwell(PBLANK, 4'b0000, 4);

        // 3: 2-cycle dwell on digit 1 is never captured; blank digit decodes to F
        base = fv_cnt;
        dwell(P5, 4'b0001, 8);
        dwell(P6, 4'b0010, 2);
        dwell(P7, 4'b0100, 8);
        dwell(PBLANK, 4'b1000, 8);
        dwell(PBLANK, 4'b0000, 4);
        chk("t3_nofv", 32'(fv_cnt - base), 32'd0);
        chk("t3_bcd_held", 32'(bus.bcd_out), 32'h4E21);
        show_until_frame(P9, 4'b0010, seen);
        chk("t3_seen", 32'(seen), 32'd1);
        chk("t3_bcd", 32'(bus.bcd_out), 32'hF795);
        chk("t3_err", 32'(bus.digit_err), 32'h0);
        dwell(PBLANK, 4'b0000, 4);

        // 4: multi-hot gaps ignored; recapture of digit 0 keeps the latest value
        base = fv_cnt;
        dwell(P5, 4'b0001, 8);
        dwell(P0, 4'b0001, 8);
        dwell(P8, 4'b0011, 10);
        dwell(P3, 4'b0010, 8);
        dwell(P8, 4'b0011, 10);
        dwell(P6, 4'b0100, 8);
        chk("t4_nofv_early", 32'(fv_cnt - base), 32'd0);
        show_until_frame(P9, 4'b1000, seen);
        chk("t4_seen", 32'(seen), 32'd1);
        chk("t4_bcd", 32'(bus.bcd_out), 32'h9630);
        chk("t4_err", 32'(bus.digit_err), 32'h0);

        // 5: stop scanning right after the frame; link_lost after exactly TO cycles
        bus.seg_in = PBLANK;
        bus.dig_en = 4'b0000;
        repeat (TO - 1) begin
            @(posedge clk);
            #1;
        end
        chk("t5_ll_before", 32'(bus.link_lost), 32'd0);
        @(posedge clk);
        #1;
        chk("t5_ll_at", 32'(bus.link_lost), 32'd1);
        chk("t5_bcd_held", 32'(bus.bcd_out), 32'h9630);
        chk("t4_fvcnt", 32'(fv_cnt - base), 32'd1);
        dwell(P1, 4'b0001, 8);
        chk("t5_ll_hold", 32'(bus.link_lost), 32'd1);
        dwell(P2, 4'b0010, 8);
        dwell(P3, 4'b0100, 8);
        show_until_frame(P4, 4'b1000, seen);
        chk("t5_seen", 32'(seen), 32'd1);
        chk("t5_ll_clr", 32'(bus.link_lost), 32'd0);
        chk("t5_bcd", 32'(bus.bcd_out), 32'h4321);
        dwell(PBLANK, 4'b0000, 4);

        // 6: reset after 3 of 4 captures discards the partial frame
        dwell(P7, 4'b0001, 8);
        dwell(P7, 4'b0010, 8);
        dwell(P7, 4'b0100, 8);
        rst = 1'b1;
        dwell(PBLANK, 4'b0000, 2);
        chk("t6_rst_bcd", 32'(bus.bcd_out), 32'hFFFF);
        chk("t6_rst_err", 32'(bus.digit_err), 32'h0);
        chk("t6_rst_ll", 32'(bus.link_lost), 32'h0);
        chk("t6_rst_fv", 32'(bus.frame_valid), 32'h0);
        rst = 1'b0;
        base = fv_cnt;
        dwell(P5, 4'b1000, 8);
        dwell(P1, 4'b0001, 8);
        dwell(P2, 4'b0010, 8);
        dwell(PBLANK, 4'b0000, 3);
        chk("t6_nofv", 32'(fv_cnt - base), 32'd0);
        show_until_frame(P3, 4'b0100, seen);
        chk("t6_seen", 32'(seen), 32'd1);
        chk("t6_bcd", 32'(bus.bcd_out), 32'h5321);
        dwell(PBLANK, 4'b0000, 4);
        chk("t6_fvcnt", 32'(fv_cnt - base), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
